// File: rtl/spi_wb_bridge.sv
// ---------------------------------------------------------------------------
// spi_wb_bridge
// SPI slave (mode 0, MSB first) acting as a single-beat Wishbone master.
// Frames: CMD (0x02 write / 0x03 read), ADRH, ADRL, then data bytes with
// address auto-increment. Reads are prefetched: the first byte after ADRL
// is a 0x00 dummy, byte N returns mem[A+N-1].
//
// Ports
//   I_wb_clk            system / Wishbone clock (SCK must be <= clk/8)
//   I_rst_n             asynchronous active-low reset
//   I_spi_sck/cs_n/mosi SPI inputs, oversampled through SYNC_STAGES flops
//   O_spi_miso          SPI data out
//   O_wb_adr/dat/we/stb/cyc, I_wb_ack, I_wb_dat  Wishbone master port
//   O_busy              Wishbone cycle outstanding
//   O_err               sticky error (overrun, underrun, timeout); cleared
//                       on CS_n falling edge
//
// Optional feature: define SPI_WB_TIMEOUT_EN to abort a Wishbone cycle
// after TIMEOUT_CYCLES clocks without ack (read data then reads as 0xFF).
// ---------------------------------------------------------------------------
module spi_wb_bridge #(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        I_wb_clk,
   input  logic        I_rst_n,
   input  logic        I_spi_sck,
   input  logic        I_spi_cs_n,
   input  logic        I_spi_mosi,
   output logic        O_spi_miso,
   output logic [15:0] O_wb_adr,
   output logic [7:0]  O_wb_dat,
   output logic        O_wb_we,
   output logic        O_wb_stb,
   output logic        O_wb_cyc,
   input  logic        I_wb_ack,
   input  logic [7:0]  I_wb_dat,
   output logic        O_busy,
   output logic        O_err
);

   typedef enum logic [2:0] {F_IDLE, F_CMD, F_ADRH, F_ADRL, F_WDATA, F_RDATA, F_IGNORE} f_state_e;
   typedef enum logic {W_IDLE, W_REQ} w_state_e;

   // ---------------- input synchronizers and edge detect ----------------
   logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
   logic sck_prev_q, cs_prev_q;
   logic sck_s, cs_s, mosi_s, sck_rise, sck_fall, cs_fall;

   always_ff @(posedge I_wb_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         sck_sync_q  <= '0;
         cs_sync_q   <= '1;   // idle deselected, so reset release never fakes a CS fall
         mosi_sync_q <= '0;
         sck_prev_q  <= 1'b0;
         cs_prev_q   <= 1'b1;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], I_spi_sck};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], I_spi_cs_n};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], I_spi_mosi};
         sck_prev_q  <= sck_s;
         cs_prev_q   <= cs_s;
      end
   end

   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign cs_s     = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s & sck_prev_q;
   assign cs_fall  = ~cs_s & cs_prev_q;

   // ---------------- state ----------------
   f_state_e f_state_q, f_state_d;
   w_state_e w_state_q, w_state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  rx_q, rx_d, tx_q, tx_d, buf_q, buf_d, rd_data_q, rd_data_d;
   logic [15:0] addr_q, addr_d, adr_q, adr_d;
   logic [7:0]  dat_q, dat_d;
   logic miso_q, miso_d, is_rd_q, is_rd_d, buf_full_q, buf_full_d;
   logic rd_req_q, rd_req_d, rd_valid_q, rd_valid_d, err_q, err_d;
   logic cyc_q, cyc_d, we_q, we_d;

   // Engine -> frame bookkeeping strobes
   logic start_wr, start_rd, wr_ack, rd_done, to_abort, to_hit;
   logic [7:0] rd_done_dat;
   logic [7:0] byte_w;

   assign byte_w = {rx_q[6:0], mosi_s};

`ifdef SPI_WB_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [TO_W-1:0] to_cnt_q;

   // Counts cycles spent in W_REQ; the abort fires in the TIMEOUT_CYCLES-th one.
   always_ff @(posedge I_wb_clk or negedge I_rst_n) begin
      if (!I_rst_n)                to_cnt_q <= '0;
      else if (w_state_q == W_REQ) to_cnt_q <= to_cnt_q + TO_W'(1);
      else                         to_cnt_q <= '0;
   end
   assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
   assign to_hit = 1'b0;
`endif

   // ---------------- registers ----------------
   always_ff @(posedge I_wb_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         f_state_q  <= F_IDLE;
         w_state_q  <= W_IDLE;
         bit_cnt_q  <= '0;
         rx_q       <= '0;
         tx_q       <= '0;
         buf_q      <= '0;
         rd_data_q  <= '0;
         addr_q     <= '0;
         adr_q      <= '0;
         dat_q      <= '0;
         miso_q     <= 1'b0;
         is_rd_q    <= 1'b0;
         buf_full_q <= 1'b0;
         rd_req_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         err_q      <= 1'b0;
         cyc_q      <= 1'b0;
         we_q       <= 1'b0;
      end else begin
         f_state_q  <= f_state_d;
         w_state_q  <= w_state_d;
         bit_cnt_q  <= bit_cnt_d;
         rx_q       <= rx_d;
         tx_q       <= tx_d;
         buf_q      <= buf_d;
         rd_data_q  <= rd_data_d;
         addr_q     <= addr_d;
         adr_q      <= adr_d;
         dat_q      <= dat_d;
         miso_q     <= miso_d;
         is_rd_q    <= is_rd_d;
         buf_full_q <= buf_full_d;
         rd_req_q   <= rd_req_d;
         rd_valid_q <= rd_valid_d;
         err_q      <= err_d;
         cyc_q      <= cyc_d;
         we_q       <= we_d;
      end
   end

   // ---------------- Wishbone engine ----------------
   always_comb begin
      w_state_d   = w_state_q;
      cyc_d       = cyc_q;
      we_d        = we_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      start_wr    = 1'b0;
      start_rd    = 1'b0;
      wr_ack      = 1'b0;
      rd_done     = 1'b0;
      to_abort    = 1'b0;
      rd_done_dat = I_wb_dat;
      case (w_state_q)
         W_IDLE: begin
            // Pending write wins so bytes land in the order they arrived.
            if (buf_full_q) begin
               start_wr  = 1'b1;
               w_state_d = W_REQ;
               cyc_d     = 1'b1;
               we_d      = 1'b1;
               adr_d     = addr_q;
               dat_d     = buf_q;
            end else if (rd_req_q) begin
               start_rd  = 1'b1;
               w_state_d = W_REQ;
               cyc_d     = 1'b1;
               we_d      = 1'b0;
               adr_d     = addr_q;
            end
         end
         W_REQ: begin
            if (I_wb_ack) begin
               w_state_d = W_IDLE;
               cyc_d     = 1'b0;
               wr_ack    = we_q;
               rd_done   = ~we_q;
            end else if (to_hit) begin
               w_state_d   = W_IDLE;
               cyc_d       = 1'b0;
               to_abort    = 1'b1;
               rd_done     = ~we_q;
               rd_done_dat = 8'hFF;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // ---------------- frame FSM / shift registers ----------------
   always_comb begin
      f_state_d  = f_state_q;
      bit_cnt_d  = bit_cnt_q;
      rx_d       = rx_q;
      tx_d       = tx_q;
      buf_d      = buf_q;
      rd_data_d  = rd_data_q;
      addr_d     = addr_q;
      miso_d     = miso_q;
      is_rd_d    = is_rd_q;
      buf_full_d = buf_full_q;
      rd_req_d   = rd_req_q;
      rd_valid_d = rd_valid_q;
      err_d      = err_q;

      // Engine bookkeeping first; frame events below may override.
      if (start_wr) buf_full_d = 1'b0;
      if (start_rd) rd_req_d = 1'b0;
      if (wr_ack)   addr_d = addr_q + 16'd1;
      if (rd_done) begin
         rd_valid_d = 1'b1;
         rd_data_d  = rd_done_dat;
      end

      if (cs_s) begin
         // Deselect aborts the frame; a byte completing now is discarded.
         f_state_d  = F_IDLE;
         bit_cnt_d  = '0;
         miso_d     = 1'b0;
         rd_req_d   = 1'b0;
         rd_valid_d = 1'b0;
      end else if (cs_fall) begin
         err_d     = 1'b0;
         f_state_d = F_CMD;
         bit_cnt_d = '0;
         tx_d      = 8'h00;
         miso_d    = 1'b0;      // bit 7 of the first (all-zero) response byte
      end else if (f_state_q != F_IDLE) begin
         // tx_q holds the not-yet-presented bits, MSB aligned.
         if (sck_fall) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
         end
         if (sck_rise) begin
            rx_d      = byte_w;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               tx_d = 8'h00;
               case (f_state_q)
                  F_CMD: begin
                     if (byte_w == 8'h02) begin
                        is_rd_d   = 1'b0;
                        f_state_d = F_ADRH;
                     end else if (byte_w == 8'h03) begin
                        is_rd_d   = 1'b1;
                        f_state_d = F_ADRH;
                     end else begin
                        f_state_d = F_IGNORE;
                     end
                  end
                  F_ADRH: begin
                     addr_d[15:8] = byte_w;
                     f_state_d    = F_ADRL;
                  end
                  F_ADRL: begin
                     addr_d[7:0] = byte_w;
                     if (is_rd_q) begin
                        f_state_d  = F_RDATA;
                        rd_req_d   = 1'b1;
                        rd_valid_d = 1'b0;
                     end else begin
                        f_state_d = F_WDATA;
                     end
                  end
                  F_WDATA: begin
                     if (buf_full_d) begin
                        err_d = 1'b1;        // overrun: byte dropped
                     end else begin
                        buf_d      = byte_w;
                        buf_full_d = 1'b1;
                     end
                  end
                  F_RDATA: begin
                     if (rd_valid_q) begin
                        tx_d       = rd_data_q;
                        rd_valid_d = 1'b0;
                        addr_d     = addr_q + 16'd1;
                        rd_req_d   = 1'b1;
                     end else begin
                        // Prefetch still outstanding: it keeps running and
                        // is consumed at a later boundary.
                        tx_d  = 8'hFF;
                        err_d = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end

      if (to_abort) err_d = 1'b1;
   end

   assign O_spi_miso = miso_q;
   assign O_wb_adr   = adr_q;
   assign O_wb_dat   = dat_q;
   assign O_wb_we    = we_q;
   assign O_wb_stb   = cyc_q;
   assign O_wb_cyc   = cyc_q;
   assign O_busy     = cyc_q;
   assign O_err      = err_q;

endmodule

// File: tb/tb_spi_wb_bridge.sv
// ---------------------------------------------------------------------------
// tb_spi_wb_bridge
// Directed bench: SPI host tasks, behavioural Wishbone slave with a byte
// memory and selectable ack behaviour, table of write/read frames plus
// hand-written corner sequences (toggling ack, ignored command, overrun,
// underrun, reset mid-frame, optional timeout).
// ---------------------------------------------------------------------------
module tb_spi_wb_bridge;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sck = 1'b0;
   logic        cs_n = 1'b1;
   logic        mosi = 1'b0;
   logic        miso;
   logic [15:0] wb_adr;
   logic [7:0]  wb_dat_o;
   logic        wb_we, wb_stb, wb_cyc, busy, err;
   logic        ack = 1'b0;
   logic [7:0]  wb_dat_i;

   always #5 clk = ~clk;

   spi_wb_bridge dut (
      .I_wb_clk   (clk),
      .I_rst_n    (rst_n),
      .I_spi_sck  (sck),
      .I_spi_cs_n (cs_n),
      .I_spi_mosi (mosi),
      .O_spi_miso (miso),
      .O_wb_adr   (wb_adr),
      .O_wb_dat   (wb_dat_o),
      .O_wb_we    (wb_we),
      .O_wb_stb   (wb_stb),
      .O_wb_cyc   (wb_cyc),
      .I_wb_ack   (ack),
      .I_wb_dat   (wb_dat_i),
      .O_busy     (busy),
      .O_err      (err)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // ---------------- Wishbone slave model ----------------
   // mode 0: ack one cycle after stb; 1: ack toggles every cycle regardless
   // of stb; 2: never ack; 3: ack after SLOW_DLY cycles.
   localparam int SLOW_DLY = 300;
   logic [7:0]  mem [0:65535];
   logic [23:0] wr_log [$];
   int          mode = 0;
   int          wcnt = 0;
   int          acks = 0;
   logic        ack_taken = 1'b0;

   assign wb_dat_i = mem[wb_adr];

   always @(posedge clk) begin
      if (mode == 1)                 ack <= ~ack;
      else if (!wb_stb || ack) begin ack <= 1'b0; wcnt <= 0; end
      else if (mode == 0)            ack <= 1'b1;
      else if (mode == 3) begin
         wcnt <= wcnt + 1;
         if (wcnt == SLOW_DLY - 1) ack <= 1'b1;
      end
      if (wb_stb && ack) begin
         acks      <= acks + 1;
         ack_taken <= 1'b1;
         if (wb_we) begin
            mem[wb_adr] <= wb_dat_o;
            wr_log.push_back({wb_adr, wb_dat_o});
         end
      end else begin
         ack_taken <= 1'b0;
      end
   end

   // cyc/stb must be low in the cycle following any consumed ack.
   always @(negedge clk) begin
      if (ack_taken) chk("stb_drop_after_ack", {30'd0, wb_stb, wb_cyc}, 32'd0);
   end

`ifdef SPI_WB_TIMEOUT_EN
   int cyc_run = 0;
   int last_cyc_len = 0;
   always @(posedge clk) begin
      if (wb_cyc) cyc_run <= cyc_run + 1;
      else begin
         if (cyc_run != 0) last_cyc_len <= cyc_run;
         cyc_run <= 0;
      end
   end
`endif

   // ---------------- SPI host tasks ----------------
   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      for (int i = 7; i >= 0; i--) begin
         mosi = tx[i];
         repeat (8) @(negedge clk);
         rx[i] = miso;
         sck = 1'b1;
         repeat (8) @(negedge clk);
         sck = 1'b0;
      end
   endtask

   task automatic frame(input logic [7:0] cmd, input logic [15:0] adr, input int n,
                        input logic [2:0][7:0] d, output logic [2:0][7:0] r);
      logic [7:0] tmp;
      r = '0;
      cs_n = 1'b0;
      repeat (8) @(negedge clk);
      spi_byte(cmd, tmp);
      spi_byte(adr[15:8], tmp);
      spi_byte(adr[7:0], tmp);
      for (int i = 0; i < n; i++) begin
         spi_byte(d[i], tmp);
         r[i] = tmp;
      end
      repeat (16) @(negedge clk);
      cs_n = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   // Wait until the engine has been idle for several consecutive cycles.
   task automatic wait_idle();
      int n = 0;
      int idle = 0;
      while (idle < 6 && n < 3000) begin
         @(negedge clk);
         n++;
         idle = busy ? 0 : idle + 1;
      end
      if (idle < 6) begin
         checks++;
         failures++;
         $display("FAIL wait_idle actual=busy required=idle within 3000 cycles");
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct packed {
      logic             is_rd;
      logic [15:0]      adr;
      logic [1:0]       n;
      logic [2:0][7:0]  d;      // bytes sent after ADRL, d[0] first
      logic [2:0][15:0] e_adr;  // expected write addresses (writes)
      logic [2:0][7:0]  e_dat;  // expected write data / MISO bytes
   } vec_t;

   vec_t vecs [6];

   function automatic vec_t mkv(input logic is_rd, input logic [15:0] adr, input logic [1:0] n,
                                input logic [2:0][7:0] d, input logic [2:0][15:0] e_adr,
                                input logic [2:0][7:0] e_dat);
      vec_t v;
      v.is_rd = is_rd;
      v.adr   = adr;
      v.n     = n;
      v.d     = d;
      v.e_adr = e_adr;
      v.e_dat = e_dat;
      return v;
   endfunction

   initial begin
      #1ms;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0][7:0] r;
      logic [7:0] tmp;

      // Writes, element order {[2],[1],[0]}; bytes go out [0] first.
      vecs[0] = mkv(1'b0, 16'h0000, 2'd1, {8'h00, 8'h00, 8'h02},
                    {16'h0000, 16'h0000, 16'h0000}, {8'h00, 8'h00, 8'h02});
      vecs[1] = mkv(1'b0, 16'hFFFF, 2'd2, {8'h00, 8'h22, 8'h11},
                    {16'h0000, 16'h0000, 16'hFFFF}, {8'h00, 8'h22, 8'h11});
      vecs[2] = mkv(1'b0, 16'h1234, 2'd3, {8'h0F, 8'h55, 8'hAA},
                    {16'h1236, 16'h1235, 16'h1234}, {8'h0F, 8'h55, 8'hAA});
      // Reads: dummy 0x00 then mem[A], mem[A+1].
      vecs[3] = mkv(1'b1, 16'h0010, 2'd3, '0, '0, {8'h3C, 8'hA5, 8'h00});
      vecs[4] = mkv(1'b1, 16'h1234, 2'd3, '0, '0, {8'h55, 8'hAA, 8'h00});
      vecs[5] = mkv(1'b1, 16'hFFFF, 2'd3, '0, '0, {8'h22, 8'h11, 8'h00});

      mem[16'h0010] = 8'hA5;
      mem[16'h0011] = 8'h3C;

      // Reset state
      repeat (5) @(negedge clk);
      chk("reset_outputs", {2'd0, wb_adr, wb_dat_o, wb_we, wb_stb, wb_cyc, busy, err, miso}, 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("post_reset_outputs", {2'd0, wb_adr, wb_dat_o, wb_we, wb_stb, wb_cyc, busy, err, miso}, 32'd0);

      // Table-driven frames
      for (int v = 0; v < 6; v++) begin
         wr_log.delete();
         frame(vecs[v].is_rd ? 8'h03 : 8'h02, vecs[v].adr, int'(vecs[v].n), vecs[v].d, r);
         wait_idle();
         if (!vecs[v].is_rd) begin
            chk($sformatf("v%0d_wr_count", v), wr_log.size(), vecs[v].n);
            for (int i = 0; i < int'(vecs[v].n); i++)
               if (i < wr_log.size())
                  chk($sformatf("v%0d_wr%0d", v, i), {8'd0, wr_log[i]},
                      {8'd0, vecs[v].e_adr[i], vecs[v].e_dat[i]});
         end else begin
            chk($sformatf("v%0d_rd_no_writes", v), wr_log.size(), 0);
            for (int i = 0; i < int'(vecs[v].n); i++)
               chk($sformatf("v%0d_miso%0d", v, i), r[i], vecs[v].e_dat[i]);
         end
         chk($sformatf("v%0d_err", v), err, 1'b0);
         $display("vector %0d rd=%0d adr=%h n=%0d done", v, vecs[v].is_rd, vecs[v].adr, vecs[v].n);
      end

      // Toggling ack: one ack consumed per cycle
      mode = 1;
      wr_log.delete();
      acks = 0;
      frame(8'h02, 16'h0200, 2, {8'h00, 8'h34, 8'h12}, r);
      wait_idle();
      chk("toggle_acks", acks, 2);
      chk("toggle_wr_count", wr_log.size(), 2);
      if (wr_log.size() == 2) begin
         chk("toggle_wr0", {8'd0, wr_log[0]}, {8'd0, 16'h0200, 8'h12});
         chk("toggle_wr1", {8'd0, wr_log[1]}, {8'd0, 16'h0201, 8'h34});
      end
      mode = 0;
      $display("toggle-ack frame done");

      // Unknown command is ignored
      wr_log.delete();
      acks = 0;
      frame(8'h05, 16'h0300, 1, {8'h00, 8'h00, 8'h99}, r);
      wait_idle();
      chk("ignore_no_cycles", acks, 0);
      chk("ignore_miso", r[0], 8'h00);
      chk("ignore_err", err, 1'b0);
      $display("ignored-command frame done");

      // Overrun: slow slave, third byte arrives with the buffer full
      mode = 3;
      wr_log.delete();
      frame(8'h02, 16'h0500, 3, {8'hC3, 8'hB2, 8'hA1}, r);
      wait_idle();
      chk("overrun_err", err, 1'b1);
      chk("overrun_wr_count", wr_log.size(), 2);
      if (wr_log.size() == 2) begin
         chk("overrun_wr0", {8'd0, wr_log[0]}, {8'd0, 16'h0500, 8'hA1});
         chk("overrun_wr1", {8'd0, wr_log[1]}, {8'd0, 16'h0501, 8'hB2});
      end
      $display("overrun frame done");

      // Underrun: prefetch not back at the boundary -> 0xFF, err
      frame(8'h03, 16'h0010, 3, '0, r);
      wait_idle();
      chk("underrun_dummy", r[0], 8'h00);
      chk("underrun_b1", r[1], 8'hFF);
      chk("underrun_b2", r[2], 8'hFF);
      chk("underrun_err", err, 1'b1);
      mode = 0;
      cs_n = 1'b0;
      repeat (8) @(negedge clk);
      chk("err_clear_on_cs_fall", err, 1'b0);
      cs_n = 1'b1;
      repeat (8) @(negedge clk);
      $display("underrun frame done");

      // Reset mid-frame during F_WDATA
      cs_n = 1'b0;
      repeat (8) @(negedge clk);
      spi_byte(8'h02, tmp);
      spi_byte(8'h06, tmp);
      spi_byte(8'h00, tmp);
      mosi = 1'b1;
      repeat (2) begin
         repeat (8) @(negedge clk);
         sck = 1'b1;
         repeat (8) @(negedge clk);
         sck = 1'b0;
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_outputs", {2'd0, wb_adr, wb_dat_o, wb_we, wb_stb, wb_cyc, busy, err, miso}, 32'd0);
      cs_n = 1'b1;
      mosi = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      wr_log.delete();
      frame(8'h02, 16'h0040, 1, {8'h00, 8'h00, 8'h77}, r);
      wait_idle();
      chk("post_reset_wr_count", wr_log.size(), 1);
      if (wr_log.size() == 1) chk("post_reset_wr0", {8'd0, wr_log[0]}, {8'd0, 16'h0040, 8'h77});
      chk("post_reset_err", err, 1'b0);
      $display("reset mid-frame sequence done");

`ifdef SPI_WB_TIMEOUT_EN
      mode = 2;
      frame(8'h03, 16'h0100, 3, '0, r);
      wait_idle();
      chk("timeout_cyc_len", last_cyc_len, 255);
      chk("timeout_err", err, 1'b1);
      chk("timeout_miso", r[2], 8'hFF);
      mode = 0;
      cs_n = 1'b0;
      repeat (8) @(negedge clk);
      chk("timeout_err_clear", err, 1'b0);
      cs_n = 1'b1;
      repeat (8) @(negedge clk);
      $display("timeout sequence done");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_wb_bridge.md
Name: spi_wb_bridge

Overview:
- SPI slave (mode 0, MSB first) that acts as the Wishbone master for the video subsystem.
- Converts host SPI frames into single-beat 16-bit-address / 8-bit-data Wishbone reads and writes, with address auto-increment.
- Sits directly upstream of the video top. Drives its I_wb_* slave port on the same I_wb_clk.
- SCK is oversampled in the Wishbone clock domain; no second clock exists.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on SCK, CS_n and MOSI (min 2).
- TIMEOUT_CYCLES, 255: I_wb_clk cycles in WB_REQ before abort (only used when the timeout macro is defined).

Ports:
- I_wb_clk  in  1  system/Wishbone clock; SCK must be ≤ I_wb_clk/8.
- I_rst_n  in  1  reset, asynchronous, active-low.
- I_spi_sck  in  1  SPI clock, idle low.
- I_spi_cs_n  in  1  frame select, active-low.
- I_spi_mosi  in  1  host data in.
- O_spi_miso  out  1  host data out.
- O_wb_adr  out  16  Wishbone address.
- O_wb_dat  out  8  write data.
- O_wb_we  out  1  write enable.
- O_wb_stb  out  1  strobe.
- O_wb_cyc  out  1  cycle.
- I_wb_ack  in  1  slave acknowledge.
- I_wb_dat  in  8  read data.
- O_busy  out  1  high while a Wishbone cycle is outstanding.
- O_err  out  1  sticky error flag; cleared on CS_n falling edge.

Behaviour:
- Interface: one clock, I_wb_clk. Reset I_rst_n is asynchronous, active-low.
- Reset values: all outputs 0. Internal FSMs go to IDLE and the address register clears.
- SPI inputs pass through SYNC_STAGES flops. Edge detect on synchronized SCK.
- MOSI is sampled on the SCK rising edge. MISO is updated on the SCK falling edge, and on CS_n falling edge for bit 7 of the first byte.
- A byte is complete on the 8th rising edge.
- CS_n high at any point:
  - Aborts the frame: bit counter → 0, frame FSM → F_IDLE, MISO → 0.
  - An in-flight Wishbone cycle still completes normally.
- Frame FSM states: F_IDLE, F_CMD, F_ADRH, F_ADRL, F_WDATA, F_RDATA, F_IGNORE.
  - CS_n fall: F_IDLE → F_CMD.
  - Command 0x02 → F_ADRH (write). Command 0x03 → F_ADRH (read). Any other value → F_IGNORE until CS_n high.
  - ADRH loads addr[15:8]; ADRL loads addr[7:0].
  - After ADRL: write command → F_WDATA; read command → F_RDATA, and the first read at addr is issued immediately.
- Write path:
  - Each completed byte in F_WDATA goes into a 1-entry holding buffer.
  - The WB engine issues a write from the buffer when idle, then increments addr after ack. 0xFFFF wraps to 0x0000.
  - A byte completing while the buffer is still full is an overrun: the byte is dropped and O_err is set.
- Read path (prefetch):
  - The first byte shifted out after ADRL is a dummy, 0x00.
  - At each byte boundary in F_RDATA, the prefetched data is loaded into the TX shift register, addr increments, and the next read is issued.
  - Byte N (N≥1) after the dummy returns mem[A+N-1].
  - If the prefetch is not yet acked at a boundary, the byte sends 0xFF and O_err is set.
- WB engine states: W_IDLE, W_REQ.
  - W_IDLE → W_REQ: cyc, stb and O_busy asserted; adr, dat and we registered and held stable.
  - In W_REQ, the first cycle I_wb_ack=1 captures I_wb_dat (on reads) and deasserts cyc/stb on that same clock edge, so they are low the next cycle. → W_IDLE.
  - I_wb_ack is ignored in W_IDLE.
  - A new request may not start in the same cycle the previous ack is seen, so there is a minimum 1 idle cycle between cycles.
- Simultaneous events: a CS_n rise in the same cycle as a byte completion discards that byte.

Optional Feature:
- Macro SPI_WB_TIMEOUT_EN.
  - Defined: an 8+ bit counter runs in W_REQ. On reaching TIMEOUT_CYCLES, the engine drops cyc/stb, sets O_err, returns 0xFF as read data, and goes to W_IDLE.
  - Not defined: W_REQ waits indefinitely for ack, and no counter is synthesized.

Test Plan:
- Write: CS low, send 0x02 0x00 0x00 0x02, CS high → one WB write adr=0x0000 dat=0x02 we=1, cyc/stb low the cycle after ack, O_err=0.
- Burst write with wrap: 0x02 0xFF 0xFF 0x11 0x22 → writes 0xFFFF=0x11 then 0x0000=0x22.
- Read: slave holds mem[0x0010]=0xA5, mem[0x0011]=0x3C; send 0x03 0x00 0x10 + 3 dummy bytes → MISO returns 0x00, 0xA5, 0x3C.
- Toggling-ack slave (ack inverts every cycle while stb high) → exactly one ack consumed, and stb low after the first ack.
- Reset mid-frame: assert I_rst_n=0 during F_WDATA → all outputs 0 asynchronously; a following clean frame works normally.
- SPI_WB_TIMEOUT_EN defined, slave never acks, read at 0x0100 → cyc/stb drop after 255 cycles, O_err=1, host receives 0xFF; O_err clears on next CS_n fall.
